motor_mix_sequencer: RTL and testbench

- Time-multiplexed mixer controller. One signed 32x32 multiply-shift unit is shared across all motor/axis pairs instead of one multiplier per axis per motor.
- Latches a roll/pitch/yaw/throttle set on `start`, then steps through NUM_MOTORS x 4 coefficient products.
- Accumulates one sum per motor and publishes all motor commands atomically with a `done` pulse.
- Sits between the PID/rate-controller outputs and the per-motor DShot/PWM output generators.

---
 rtl/mixer_pkg.sv | 28 ++
 rtl/mix_mac.sv | 71 +++++++
 rtl/motor_mix_sequencer.sv | 172 +++++++++++++++++
 tb/tb_motor_mix_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// rtl/mixer_pkg.sv - shared constants, Q4.28 values and state encoding for the motor mixer
//
// Imported by motor_mix_sequencer and mix_mac. No ports.

package mixer_pkg;

    localparam int AXIS_THROTTLE = 0;
    localparam int AXIS_ROLL     = 1;
    localparam int AXIS_PITCH    = 2;
    localparam int AXIS_YAW      = 3;
    localparam int AXES          = 4;

    localparam int FRAC_BITS_DEF = 28;

    // Q4.28 unity and negative unity
    localparam logic [31:0] ONE     = 32'h1000_0000;
    localparam logic [31:0] NEG_ONE = 32'hF000_0000;

    // Product index width: covers up to 8 motors x 4 axes plus one past the end
    localparam int IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAC    = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/mix_mac.sv
// rtl/mix_mac.sv - shared signed 32x32 multiply, arithmetic shift and 32-bit truncate
//
// Ports:
//   clk, reset_n, flush   only present with MOTOR_MIX_MULT_PIPE_EN
//   in_valid / in_tag     product request and its index tag
//   coef, operand         signed Q4.28 coefficient and signed axis demand
//   out_valid / out_tag   result qualifier and tag, aligned with term
//   term                  (coef * operand) >>> FRAC_BITS, bits [31:0]
// Macro MOTOR_MIX_MULT_PIPE_EN inserts one register stage after the shift.

module mix_mac #(
    parameter int FRAC_BITS = 28,
    parameter int TAG_W     = 6
) (
`ifdef MOTOR_MIX_MULT_PIPE_EN
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
`endif
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [31:0]      coef,
    input  logic [31:0]      operand,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      term
);

    logic signed [63:0] coef_ext;
    logic signed [63:0] operand_ext;
    logic        [31:0] term_c;

    // Sign-extend both operands so the low 64 bits of the product are exact;
    // >>> on the signed product gives floor rounding for negative results.
    assign coef_ext    = {{32{coef[31]}}, coef};
    assign operand_ext = {{32{operand[31]}}, operand};
    assign term_c      = 32'((coef_ext * operand_ext) >>> FRAC_BITS);

`ifdef MOTOR_MIX_MULT_PIPE_EN
    logic             pipe_valid_q, pipe_valid_d;
    logic [TAG_W-1:0] pipe_tag_q,   pipe_tag_d;
    logic [31:0]      pipe_term_q,  pipe_term_d;

    always_comb begin
        pipe_valid_d = in_valid && !flush;
        pipe_tag_d   = in_tag;
        pipe_term_d  = term_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid_q <= 1'b0;
            pipe_tag_q   <= '0;
            pipe_term_q  <= '0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_tag_q   <= pipe_tag_d;
            pipe_term_q  <= pipe_term_d;
        end
    end

    assign out_valid = pipe_valid_q;
    assign out_tag   = pipe_tag_q;
    assign term      = pipe_term_q;
`else
    assign out_valid = in_valid;
    assign out_tag   = in_tag;
    assign term      = term_c;
`endif

endmodule

// File: rtl/motor_mix_sequencer.sv
// rtl/motor_mix_sequencer.sv - time-multiplexed motor mixer sharing one multiply-shift unit
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 single-cycle mix request
//   armed, failsafe       safety inputs; disarm or failsafe forces motor_out to 0
//   in_throttle/roll/pitch/yaw   signed 32-bit demands, latched on accepted start
//   busy                  high while a mix sequence runs
//   done                  one-cycle pulse, motor_out updated in the same cycle
//   motor_out             NUM_MOTORS x 32-bit signed commands, motor m at [m*32 +: 32]
// Macro MOTOR_MIX_MULT_PIPE_EN adds a pipe stage in mix_mac (one extra cycle of latency).

module motor_mix_sequencer
    import mixer_pkg::*;
#(
    parameter int                             NUM_MOTORS = 4,
    parameter int                             FRAC_BITS  = FRAC_BITS_DEF,
    parameter logic [NUM_MOTORS*AXES*32-1:0]  MIX_COEFFS = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     armed,
    input  logic                     failsafe,
    input  logic [31:0]              in_throttle,
    input  logic [31:0]              in_roll,
    input  logic [31:0]              in_pitch,
    input  logic [31:0]              in_yaw,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_MOTORS*32-1:0] motor_out
);

    localparam int TOTAL = NUM_MOTORS * AXES;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [31:0]             acc_q, acc_d;
    logic [31:0]             in_q [AXES];
    logic [31:0]             in_d [AXES];
    logic [31:0]             shadow_q [NUM_MOTORS];
    logic [31:0]             shadow_d [NUM_MOTORS];
    logic [NUM_MOTORS*32-1:0] motor_out_q, motor_out_d;

    logic             abort;
    logic             issue_valid;
    logic [31:0]      coef;
    logic [31:0]      operand;
    logic             term_valid;
    logic [IDX_W-1:0] term_idx;
    logic [31:0]      term;
    logic [31:0]      acc_sum;

    assign abort       = !armed || failsafe;
    // In the piped build idx runs one past the end while the last product drains
    assign issue_valid = (state_q == MAC) && (idx_q < IDX_W'(TOTAL));
    assign operand     = in_q[idx_q[1:0]];

    always_comb begin
        coef = '0;
        for (int i = 0; i < TOTAL; i++) begin
            if (idx_q == IDX_W'(i)) coef = MIX_COEFFS[i*32 +: 32];
        end
    end

    mix_mac #(
        .FRAC_BITS (FRAC_BITS),
        .TAG_W     (IDX_W)
    ) u_mac (
`ifdef MOTOR_MIX_MULT_PIPE_EN
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (abort),
`endif
        .in_valid  (issue_valid),
        .in_tag    (idx_q),
        .coef      (coef),
        .operand   (operand),
        .out_valid (term_valid),
        .out_tag   (term_idx),
        .term      (term)
    );

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        idx_d       = idx_q;
        acc_d       = acc_q;
        in_d        = in_q;
        shadow_d    = shadow_q;
        motor_out_d = motor_out_q;
        acc_sum     = acc_q + term;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    in_d[AXIS_THROTTLE] = in_throttle;
                    in_d[AXIS_ROLL]     = in_roll;
                    in_d[AXIS_PITCH]    = in_pitch;
                    in_d[AXIS_YAW]      = in_yaw;
                    idx_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (issue_valid) idx_d = idx_q + IDX_W'(1);
                // Accumulation follows the tag coming out of mix_mac, so it
                // stays aligned with its idx whether or not the pipe is present.
                if (term_valid) begin
                    if (term_idx[1:0] == 2'(AXIS_YAW)) begin
                        for (int m = 0; m < NUM_MOTORS; m++) begin
                            if (term_idx[IDX_W-1:2] == (IDX_W-2)'(m)) shadow_d[m] = acc_sum;
                        end
                        acc_d = '0;
                    end else begin
                        acc_d = acc_sum;
                    end
                    if (term_idx == IDX_W'(TOTAL - 1)) state_d = COMMIT;
                end
            end
            COMMIT: begin
                for (int m = 0; m < NUM_MOTORS; m++) motor_out_d[m*32 +: 32] = shadow_q[m];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Safety override wins over every other update
        if (abort) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            idx_d       = '0;
            acc_d       = '0;
            motor_out_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            idx_q       <= '0;
            acc_q       <= '0;
            in_q        <= '{default: '0};
            shadow_q    <= '{default: '0};
            motor_out_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            in_q        <= in_d;
            shadow_q    <= shadow_d;
            motor_out_q <= motor_out_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign motor_out = motor_out_q;

endmodule

// File: tb/tb_motor_mix_sequencer.sv
// tb/tb_motor_mix_sequencer.sv - directed self-checking bench for motor_mix_sequencer
//
// Honours MOTOR_MIX_MULT_PIPE_EN for the expected latency.

module tb_motor_mix_sequencer;
    import mixer_pkg::*;

`ifdef MOTOR_MIX_MULT_PIPE_EN
    localparam int EXP_LAT = 18;
`else
    localparam int EXP_LAT = 17;
`endif

    // Flat coefficients, motor m axis a at [(m*4+a)*32]; listed MSB (m3 yaw) first
    localparam logic [511:0] COEFFS = {
        32'h2000_0000, NEG_ONE,      32'h0,        32'h0,          // m3: yaw 2.0, pitch -1
        32'h0,         32'h0,        ONE,          ONE,            // m2: roll 1, throttle 1
        32'h0,         32'h0,        32'h0,        32'h0800_0000,  // m1: throttle 0.5
        NEG_ONE,       ONE,          NEG_ONE,      ONE             // m0: quad-X style
    };

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         armed = 1'b1;
    logic         failsafe = 1'b0;
    logic [31:0]  in_throttle = '0;
    logic [31:0]  in_roll = '0;
    logic [31:0]  in_pitch = '0;
    logic [31:0]  in_yaw = '0;
    logic         busy;
    logic         done;
    logic [127:0] motor_out;

    int vec_cnt = 0;
    int miscompare_cnt = 0;

    logic [31:0] vin     [4][4];   // [vector][thr, roll, pitch, yaw]
    logic [31:0] exp_tab [5][4];   // [vector][motor]; row 4 is all zero
    logic [31:0] cap     [4];

    motor_mix_sequencer #(
        .NUM_MOTORS (4),
        .FRAC_BITS  (28),
        .MIX_COEFFS (COEFFS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .armed       (armed),
        .failsafe    (failsafe),
        .in_throttle (in_throttle),
        .in_roll     (in_roll),
        .in_pitch    (in_pitch),
        .in_yaw      (in_yaw),
        .busy        (busy),
        .done        (done),
        .motor_out   (motor_out)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vec_cnt++;
        if (got !== expv) begin
            miscompare_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic check_motors(input string tag, input int v);
        for (int m = 0; m < 4; m++)
            check_vec($sformatf("%s_m%0d", tag, m), motor_out[m*32 +: 32], exp_tab[v][m]);
    endtask

    task automatic drive_vec(input int v);
        in_throttle = vin[v][0];
        in_roll     = vin[v][1];
        in_pitch    = vin[v][2];
        in_yaw      = vin[v][3];
    endtask

    // Issues start at a negedge; returns the number of edges after edge 0 until done
    task automatic run_mix(input int v, output int lat);
        drive_vec(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int dones;
        logic seen_busy;

        vin[0] = '{32'h0800_0000, 32'h0100_0000, 32'h0,         32'h0};
        vin[1] = '{32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0};
        vin[2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0,         32'h0};
        vin[3] = '{32'h0,         32'h0,         32'h0300_0000, 32'h0100_0000};
        exp_tab[0] = '{32'h0700_0000, 32'h0400_0000, 32'h0900_0000, 32'h0};
        exp_tab[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        exp_tab[2] = '{32'h0,         32'h3FFF_FFFF, 32'hFFFF_FFFE, 32'h0};
        exp_tab[3] = '{32'h0200_0000, 32'h0,         32'h0,         32'hFF00_0000};
        exp_tab[4] = '{32'h0,         32'h0,         32'h0,         32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check_vec("rst_busy", busy, 1'b0);
        check_vec("rst_done", done, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check_motors("rst", 4);

        // Quad-X mix: latency and first-cycle busy
        drive_vec(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_vec("v1_busy", busy, 1'b1);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_vec("v1_lat", 32'(lat), 32'(EXP_LAT));
        check_vec("v1_busy_done", busy, 1'b0);
        check_motors("v1", 0);
        @(negedge clk);
        check_vec("v1_done_pulse", done, 1'b0);
        check_motors("v1_hold", 0);

        // Floor rounding, overflow wrap, pitch/yaw
        run_mix(1, lat);
        check_vec("v2_lat", 32'(lat), 32'(EXP_LAT));
        check_motors("v2", 1);
        run_mix(2, lat);
        check_vec("v3_lat", 32'(lat), 32'(EXP_LAT));
        check_motors("v3", 2);
        run_mix(3, lat);
        check_vec("v4_lat", 32'(lat), 32'(EXP_LAT));
        check_motors("v4", 3);

        // start during busy ignored; in_roll change during MAC ignored
        drive_vec(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        lat = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 3) begin
                in_roll = 32'h7000_0000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    lat = c;
                    for (int m = 0; m < 4; m++) cap[m] = motor_out[m*32 +: 32];
                end
            end
        end
        check_vec("ign_dones", 32'(dones), 32'd1);
        check_vec("ign_lat", 32'(lat), 32'(EXP_LAT));
        for (int m = 0; m < 4; m++) check_vec($sformatf("ign_m%0d", m), cap[m], exp_tab[0][m]);

        // Failsafe at MAC cycle 8
        drive_vec(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        failsafe = 1'b1;
        @(negedge clk);
        check_vec("fs_busy", busy, 1'b0);
        check_vec("fs_done", done, 1'b0);
        check_motors("fs", 4);
        failsafe = 1'b0;
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check_vec("fs_no_done", 32'(dones), 32'd0);
        run_mix(2, lat);
        check_vec("fs_rerun_lat", 32'(lat), 32'(EXP_LAT));
        check_motors("fs_rerun", 2);

        // Asynchronous reset mid-MAC
        drive_vec(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_vec("arst_busy", busy, 1'b0);
        check_vec("arst_done", done, 1'b0);
        check_motors("arst", 4);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_mix(3, lat);
        check_vec("arst_rerun_lat", 32'(lat), 32'(EXP_LAT));
        check_motors("arst_rerun", 3);

        // Disarmed: outputs forced to 0, start ignored
        armed = 1'b0;
        @(negedge clk);
        check_motors("disarm", 4);
        drive_vec(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_busy = busy;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy === 1'b1) seen_busy = 1'b1;
            if (done === 1'b1) dones++;
        end
        check_vec("disarm_busy", seen_busy, 1'b0);
        check_vec("disarm_dones", 32'(dones), 32'd0);
        check_motors("disarm_hold", 4);
        armed = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
